// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: shared widths and the request type carried by the writeback path.
package writeback_arbiter_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// wb_fifo: synchronous FIFO of typed entries with push/pop/full/empty/count.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_req_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;
  assign full_o  = r_cnt == CW'(DEPTH);
  assign empty_o = r_cnt == '0;
  assign count_o = r_cnt;
  assign data_o  = r_mem[r_rd];
  assign w_pop   = pop_i && !empty_o;
  // a pop frees the head slot, so a push into a full FIFO is safe in the same cycle
  assign w_push  = push_i && (!full_o || pop_i);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges pipeline writeback and buffered MDU results onto the
// register-file write port, tracks outstanding MDU destinations and requests stalls.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W,
  parameter int DATA_WIDTH    = DATA_W,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wb_valid_i,
  input  logic [ADDRESS_WIDTH-1:0]    wb_rd_i,
  input  logic [DATA_WIDTH-1:0]       wb_data_i,
  input  logic                        mdu_issue_i,
  input  logic [ADDRESS_WIDTH-1:0]    mdu_issue_rd_i,
  input  logic                        mdu_valid_i,
  input  logic [ADDRESS_WIDTH-1:0]    mdu_rd_i,
  input  logic [DATA_WIDTH-1:0]       mdu_data_i,
  output logic                        mdu_ready_o,
  output logic                        rf_we_o,
  output logic [ADDRESS_WIDTH-1:0]    rf_addr_o,
  output logic [DATA_WIDTH-1:0]       rf_wd_o,
  output logic [2**ADDRESS_WIDTH-1:0] busy_mask_o,
  output logic                        stall_o
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam int NR = 2**ADDRESS_WIDTH;
  wb_req_t              w_head;
  wb_req_t              w_sel;
  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic [CW-1:0]        w_count_nxt;
  logic                 w_push;
  logic                 w_wb_sel;
  logic                 w_drain;
  logic                 w_we_nxt;
  logic [NR-1:0]        w_set;
  logic [NR-1:0]        w_clr;
  logic [SW-1:0]        w_starve_nxt;
  logic                 r_we;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wd;
  logic [NR-1:0]        r_busy;
  logic [SW-1:0]        r_starve;
  logic                 r_stall;
  assign mdu_ready_o = !w_full;
  assign w_push      = mdu_valid_i && mdu_ready_o;
  assign rf_we_o     = r_we;
  assign rf_addr_o   = r_addr;
  assign rf_wd_o     = r_wd;
  assign busy_mask_o = r_busy;
  assign stall_o     = r_stall;
  wb_fifo #(.DEPTH(FIFO_DEPTH), .T(wb_req_t)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (w_push),
    .data_i (wb_req_t'{rd: mdu_rd_i, data: mdu_data_i}),
    .pop_i  (w_drain),
    .data_o (w_head),
    .full_o (w_full),
    .empty_o(w_empty),
    .count_o(w_count)
  );
  // x0 pipeline writes count as an empty slot; x0 FIFO heads pop without writing
  always_comb begin
    w_wb_sel     = wb_valid_i && (wb_rd_i != '0);
    w_drain      = !w_wb_sel && !w_empty;
    w_sel        = w_wb_sel ? wb_req_t'{rd: wb_rd_i, data: wb_data_i} : w_head;
    w_we_nxt     = w_wb_sel || (w_drain && (w_head.rd != '0));
    w_set        = (mdu_issue_i && (mdu_issue_rd_i != '0)) ? NR'(1) << mdu_issue_rd_i : '0;
    w_clr        = (w_drain && (w_head.rd != '0)) ? NR'(1) << w_head.rd : '0;
    w_count_nxt  = w_count + CW'(w_push) - CW'(w_drain);
    w_starve_nxt = (w_empty || w_drain) ? '0 :
                   (r_starve == SW'(STARVE_LIMIT)) ? r_starve : r_starve + SW'(1);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wd     <= '0;
      r_busy   <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_we     <= w_we_nxt;
      r_addr   <= w_we_nxt ? w_sel.rd : '0;
      r_wd     <= w_we_nxt ? w_sel.data : '0;
      r_busy   <= (r_busy & ~w_clr) | w_set;
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == SW'(STARVE_LIMIT)) || (w_count_nxt == CW'(FIFO_DEPTH));
    end
  end
  a_issue_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mdu_issue_i && (mdu_issue_rd_i != '0) && r_busy[mdu_issue_rd_i]));
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed stimulus with a write scoreboard and a decoupled monitor.
module tb_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        wb_valid_i = 1'b0;
  logic [4:0]  wb_rd_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        mdu_issue_i = 1'b0;
  logic [4:0]  mdu_issue_rd_i = '0;
  logic        mdu_valid_i = 1'b0;
  logic [4:0]  mdu_rd_i = '0;
  logic [31:0] mdu_data_i = '0;
  logic        mdu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_wd_o;
  logic [31:0] busy_mask_o;
  logic        stall_o;
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int mon_checks = 0;
  int mon_fails = 0;
  always #5 clk = ~clk;
  writeback_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .mdu_issue_i(mdu_issue_i), .mdu_issue_rd_i(mdu_issue_rd_i),
    .mdu_valid_i(mdu_valid_i), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
    .mdu_ready_o(mdu_ready_o), .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o),
    .rf_wd_o(rf_wd_o), .busy_mask_o(busy_mask_o), .stall_o(stall_o)
  );
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && rf_we_o) begin
      mon_checks++;
      if (exp_q.size() == 0) begin
        mon_fails++;
        $display("FAIL unexpected_write got addr=%0d data=%h required no write", rf_addr_o, rf_wd_o);
      end else begin
        e = exp_q.pop_front();
        if (rf_addr_o !== e.a || rf_wd_o !== e.d) begin
          mon_fails++;
          $display("FAIL rf_write got addr=%0d data=%h required addr=%0d data=%h",
                   rf_addr_o, rf_wd_o, e.a, e.d);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", n, act, req);
    end
  endtask
  task automatic idle();
    wb_valid_i = 1'b0;
    mdu_valid_i = 1'b0;
    mdu_issue_i = 1'b0;
  endtask
  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask
  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_valid_i = 1'b1;
    wb_rd_i = rd;
    wb_data_i = d;
    if (rd != 0) expect_wr(rd, d);
  endtask
  task automatic mdu(input logic [4:0] rd, input logic [31:0] d);
    mdu_valid_i = 1'b1;
    mdu_rd_i = rd;
    mdu_data_i = d;
  endtask
  task automatic issue(input logic [4:0] rd);
    mdu_issue_i = 1'b1;
    mdu_issue_rd_i = rd;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    #1 rst_i = 1'b1;
    #1;
    chk("reset_we", 64'(rf_we_o), 0);
    chk("reset_addr", 64'(rf_addr_o), 0);
    chk("reset_wd", 64'(rf_wd_o), 0);
    chk("reset_busy", 64'(busy_mask_o), 0);
    chk("reset_stall", 64'(stall_o), 0);
    step();
    step();
    rst_i = 1'b0;
    step();
    chk("ready_after_reset", 64'(mdu_ready_o), 1);
    // single pipeline write appears for exactly one cycle
    wb(5, 32'hDEADBEEF);
    step();
    idle();
    chk("wb_we_on", 64'(rf_we_o), 1);
    step();
    chk("wb_we_off", 64'(rf_we_o), 0);
    // scoreboard set by issue, cleared on the edge that registers the drain
    issue(7);
    step();
    idle();
    chk("busy7_set", 64'(busy_mask_o[7]), 1);
    mdu(7, 42);
    step();
    idle();
    expect_wr(7, 42);
    step();
    chk("drain7_we", 64'(rf_we_o), 1);
    chk("busy7_clr", 64'(busy_mask_o[7]), 0);
    step();
    // fill the FIFO behind continuous pipeline writes
    for (int i = 0; i < 4; i++) begin
      wb(5'(10 + i), 32'(100 + i));
      mdu(5'(1 + i), 32'(200 + i));
      step();
    end
    idle();
    chk("full_ready", 64'(mdu_ready_o), 0);
    chk("full_stall", 64'(stall_o), 1);
    for (int i = 0; i < 4; i++) expect_wr(5'(1 + i), 32'(200 + i));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_we", 64'(rf_we_o), 1);
      if (i == 0) chk("stall_drop", 64'(stall_o), 0);
    end
    step();
    chk("drained_ready", 64'(mdu_ready_o), 1);
    chk("drained_we", 64'(rf_we_o), 0);
    // starvation: one queued result under 9 cycles of pipeline writes
    mdu(9, 300);
    for (int i = 0; i < 9; i++) begin
      wb(5'(20 + i), 32'(400 + i));
      step();
      mdu_valid_i = 1'b0;
      if (i == 7) chk("starve_pre", 64'(stall_o), 0);
    end
    chk("starve_stall", 64'(stall_o), 1);
    idle();
    expect_wr(9, 300);
    step();
    chk("starve_release", 64'(stall_o), 0);
    chk("starve_drain_addr", 64'(rf_addr_o), 9);
    // x0 pipeline slot lets rd=3 drain; x0 FIFO head pops silently
    wb(0, 32'h111);
    mdu(3, 500);
    step();
    wb(0, 32'h222);
    mdu(0, 600);
    expect_wr(3, 500);
    step();
    mdu_valid_i = 1'b0;
    chk("x0_drain_addr", 64'(rf_addr_o), 3);
    step();
    idle();
    chk("x0_head_we", 64'(rf_we_o), 0);
    step();
    chk("x0_empty_ready", 64'(mdu_ready_o), 1);
    // reset in the middle of draining three queued results
    issue(11);
    wb(21, 32'h700);
    step();
    issue(12);
    wb(22, 32'h701);
    mdu(11, 32'h800);
    step();
    issue(13);
    wb(23, 32'h702);
    mdu(12, 32'h801);
    step();
    mdu_issue_i = 1'b0;
    wb(24, 32'h703);
    mdu(13, 32'h802);
    step();
    idle();
    expect_wr(11, 32'h800);
    step();
    chk("mid_busy", 64'(busy_mask_o), 64'((32'd1 << 12) | (32'd1 << 13)));
    @(negedge clk);
    #1;
    chk("mid_queue_empty", 64'(exp_q.size()), 0);
    rst_i = 1'b1;
    #1;
    chk("rst_we", 64'(rf_we_o), 0);
    chk("rst_addr", 64'(rf_addr_o), 0);
    chk("rst_wd", 64'(rf_wd_o), 0);
    chk("rst_busy", 64'(busy_mask_o), 0);
    chk("rst_stall", 64'(stall_o), 0);
    exp_q.delete();
    step();
    step();
    rst_i = 1'b0;
    step();
    chk("post_rst_ready", 64'(mdu_ready_o), 1);
    chk("post_rst_busy", 64'(busy_mask_o), 0);
    step();
    step();
    step();
    chk("post_rst_we", 64'(rf_we_o), 0);
    chk("final_queue_empty", 64'(exp_q.size()), 0);
    @(negedge clk);
    #1;
    checks += mon_checks;
    failures += mon_fails;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
